// File: rtl/gpio_bank_pkg.sv
// Shared types and default parameters for the GPIO bank.
package gpio_bank_pkg;

  typedef enum logic [1:0] {
    LISTEN = 2'd0,
    TURN   = 2'd1,
    DRIVE  = 2'd2
  } gpio_state_e;

  localparam int DEF_NUM_IO      = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FILT_CYCLES = 3;
  localparam int DEF_TURN_CYCLES = 2;

endpackage

// File: rtl/gpio_bank_chan.sv
// One pad channel: direction FSM with hi-Z dead time, plus a synchronised,
// glitch-filtered input path with edge pulses.
module gpio_bank_chan
  import gpio_bank_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_CYCLES = DEF_FILT_CYCLES,
  parameter int TURN_CYCLES = DEF_TURN_CYCLES
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic cfg_done_i,
  input  logic a_i,
  input  logic dir_i,
  input  logic pad_i,
  output logic pad_o,
  output logic oe_o,
  output logic y_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int TW = $clog2(TURN_CYCLES + 1);
  localparam int FW = $clog2(FILT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TURN_CYCLES - 1);
  localparam logic [FW-1:0] FLAST = FW'(FILT_CYCLES - 1);

  gpio_state_e         state_q, state_d;
  gpio_state_e         tgt_q, tgt_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic                a_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [FW-1:0]       fcnt_q, fcnt_d;
  logic                y_q, y_d, rise_q, rise_d, fall_q, fall_d;
  logic                s;

  // State register
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= LISTEN;
      tgt_q   <= LISTEN;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Next state: a direction request that disagrees with the current TURN
  // target restarts the dead time toward the new direction.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    tcnt_d  = tcnt_q;
    if (!cfg_done_i) begin
      state_d = LISTEN;
      tgt_d   = LISTEN;
      tcnt_d  = '0;
    end else begin
      unique case (state_q)
        LISTEN: if (!dir_i) begin
          state_d = TURN;
          tgt_d   = DRIVE;
          tcnt_d  = '0;
        end
        DRIVE: if (dir_i) begin
          state_d = TURN;
          tgt_d   = LISTEN;
          tcnt_d  = '0;
        end
        TURN: begin
          if ((dir_i ? LISTEN : DRIVE) != tgt_q) begin
            tgt_d  = dir_i ? LISTEN : DRIVE;
            tcnt_d = '0;
          end else if (tcnt_q == TLAST) begin
            state_d = tgt_q;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
        default: state_d = LISTEN;
      endcase
    end
  end

  // Outputs: dropping cfg_done releases the pad in the same cycle.
  always_comb begin
    oe_o  = (state_q == DRIVE) && cfg_done_i;
    pad_o = a_q;
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    fcnt_d = '0;
    y_d    = y_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (!cfg_done_i) begin
      y_d = 1'b0;
    end else if (s != y_q) begin
      if (fcnt_q == FLAST) begin
        y_d    = s;
        rise_d = s;
        fall_d = !s;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      a_q    <= 1'b0;
      sync_q <= '0;
      fcnt_q <= '0;
      y_q    <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      a_q    <= a_i;
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
      fcnt_q <= fcnt_d;
      y_q    <= y_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign y_o    = y_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/gpio_bank.sv
// Bank of independent bidirectional GPIO channels sharing clock, reset and
// configuration gate.
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int NUM_IO      = DEF_NUM_IO,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_CYCLES = DEF_FILT_CYCLES,
  parameter int TURN_CYCLES = DEF_TURN_CYCLES
) (
  input  logic              CK,
  input  logic              RSTN,
  input  logic              CONFIG_DONE,
  input  logic [NUM_IO-1:0] A,
  input  logic [NUM_IO-1:0] DIR,
  inout  wire  [NUM_IO-1:0] PAD,
  output logic [NUM_IO-1:0] Y,
  output logic [NUM_IO-1:0] RISE,
  output logic [NUM_IO-1:0] FALL,
  output logic [NUM_IO-1:0] OE
);

  logic [NUM_IO-1:0] pad_out;

  for (genvar i = 0; i < NUM_IO; i++) begin : g_chan
    gpio_bank_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_CYCLES(FILT_CYCLES),
      .TURN_CYCLES(TURN_CYCLES)
    ) u_chan (
      .clk_i     (CK),
      .rstn_i    (RSTN),
      .cfg_done_i(CONFIG_DONE),
      .a_i       (A[i]),
      .dir_i     (DIR[i]),
      .pad_i     (PAD[i]),
      .pad_o     (pad_out[i]),
      .oe_o      (OE[i]),
      .y_o       (Y[i]),
      .rise_o    (RISE[i]),
      .fall_o    (FALL[i])
    );
    assign PAD[i] = OE[i] ? pad_out[i] : 1'bz;
  end

endmodule

// File: doc/gpio_bank.md
GPIO_BANK -- requirements
Module: gpio_bank

Interface
REQ-001 Parameter NUM_IO, 8, number of independent pad channels (>=1).
REQ-002 Parameter SYNC_STAGES, 2, input synchroniser depth (>=2).
REQ-003 Parameter FILT_CYCLES, 3, consecutive stable cycles before Y changes (>=1).
REQ-004 Parameter TURN_CYCLES, 2, hi-Z dead-time cycles on every direction change (>=1).
REQ-005 Port CK  input  1  clock; all state updates on rising edge.
REQ-006 Port RSTN  input  1  reset; one clock, synchronous, active-low.
REQ-007 Port CONFIG_DONE  input  1  1 = bank operational; 0 = all channels forced to input, outputs blocked.
REQ-008 Port A  input  NUM_IO  data to drive onto PAD per channel.
REQ-009 Port DIR  input  NUM_IO  per-channel direction; 1 = input (listen), 0 = output (drive).
REQ-010 Port PAD  inout  NUM_IO  bidirectional pads.
REQ-011 Port Y  output  NUM_IO  synchronised, glitch-filtered pad value.
REQ-012 Port RISE  output  NUM_IO  one-cycle pulse when Y goes 0->1.
REQ-013 Port FALL  output  NUM_IO  one-cycle pulse when Y goes 1->0.
REQ-014 Port OE  output  NUM_IO  1 when channel is actively driving PAD.

Function
REQ-015 Each channel SHALL run an independent FSM with states LISTEN, TURN, DRIVE; OE=1 only in DRIVE.
REQ-016 PAD[i] SHALL be driven with registered A[i] in DRIVE, high-impedance in LISTEN and TURN.
REQ-017 Registered A SHALL capture A every cycle; A-to-PAD latency SHALL be 1 cycle in DRIVE.
REQ-018 LISTEN with CONFIG_DONE=1 and DIR=0 SHALL enter TURN with target DRIVE; DRIVE with DIR=1 SHALL enter TURN with target LISTEN.
REQ-019 TURN SHALL last exactly TURN_CYCLES cycles, then enter its target state.
REQ-020 A DIR change during TURN SHALL reload the dead-time counter and retarget to the new direction.
REQ-021 CONFIG_DONE=0 SHALL force LISTEN on the next edge from any state, clear the turn counter, and release PAD (PAD hi-Z in that cycle, combinationally).
REQ-022 Input path SHALL stay active in all FSM states (DRIVE gives loopback readback).
REQ-023 PAD SHALL pass through SYNC_STAGES flops; filter counter SHALL increment while synced value != Y, clear when equal.
REQ-024 Y SHALL take the synced value on the edge where the counter would reach FILT_CYCLES; PAD-to-Y latency SHALL be SYNC_STAGES+FILT_CYCLES cycles.
REQ-025 A pulse shorter than FILT_CYCLES cycles after synchronisation SHALL NOT change Y.
REQ-026 RISE/FALL SHALL be registered and asserted in the same cycle Y first shows its new value, for exactly one cycle.
REQ-027 While CONFIG_DONE=0, Y, RISE, FALL SHALL be held 0 and filter counters cleared; synchronisers keep sampling.
REQ-028 On CONFIG_DONE rising, a pad held high SHALL produce Y=1 and a RISE pulse after FILT_CYCLES cycles.
REQ-029 Filter counter width SHALL be clog2(FILT_CYCLES+1), saturating; turn counter width clog2(TURN_CYCLES+1).

Reset
REQ-030 RSTN=0 at an edge SHALL set all FSMs to LISTEN, counters, synchroniser flops, registered A, Y, RISE, FALL, OE to 0, PAD hi-Z.
REQ-031 Reset asserted mid-TURN or mid-filter SHALL abort the operation with no pulse emitted.
REQ-032 Reset SHALL take priority over CONFIG_DONE and DIR.

Structure
REQ-033 Package gpio_bank_pkg SHALL hold the FSM state enum (LISTEN, TURN, DRIVE) and default parameter constants.
REQ-034 One sub-module gpio_bank_chan SHALL implement a single channel; gpio_bank SHALL instantiate it NUM_IO times by generate loop.

Verification (NUM_IO=4, SYNC_STAGES=2, FILT_CYCLES=3, TURN_CYCLES=2)
REQ-035 CONFIG_DONE=1, DIR[0] 1->0, A[0]=1 -> PAD[0] hi-Z 2 cycles, then OE[0]=1 and PAD[0]=1; DIR[0] 0->1 -> PAD[0] hi-Z next cycle, OE[0]=0.
REQ-036 DIR[1]=1, PAD[1] 0->1 held -> Y[1]=1 exactly 5 cycles later with RISE[1] high for one cycle; later 1->0 -> FALL[1] pulse.
REQ-037 PAD[2] 2-cycle high glitch -> Y[2] stays 0, RISE[2] never asserts.
REQ-038 DIR[3] toggles 0->1->0 within TURN -> counter restarts; DRIVE reached 2 cycles after last toggle, PAD never driven in between.
REQ-039 CONFIG_DONE dropped while all channels DRIVE -> PAD all hi-Z immediately, OE=0, Y=0 next edge.
REQ-040 RSTN=0 for one cycle mid-TURN and mid-filter -> all outputs 0, FSM LISTEN, no RISE/FALL after release.
